// File: rtl/inverter_edge_meter_if.sv
// Control and measurement signal bundle for the inverter edge meter.
// The master side is the test controller; the meter is the slave.
interface inverter_edge_meter_if #(
   parameter int CNT_W  = 16,
   parameter int GATE_W = 16
);
   logic              start;
   logic [GATE_W-1:0] gate_len;
   logic              sig_in;
   logic              stim_out;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output start, gate_len, sig_in,
      input  stim_out, busy, done, count, overflow
   );

   modport slave (
      input  start, gate_len, sig_in,
      output stim_out, busy, done, count, overflow
   );
endinterface

// File: rtl/inverter_edge_meter.sv
// Square-wave stimulus driver and gated rising-edge counter for the inverter macro.
// One measurement per start: ARM clears state, GATE counts for gate_len cycles, DONE pulses.
module inverter_edge_meter #(
   parameter int CNT_W     = 16,
   parameter int GATE_W    = 16,
   parameter int STIM_HALF = 4
) (
   input logic                 clk,
   input logic                 rst,
   inverter_edge_meter_if.slave bus
);

   localparam int DIV_W = (STIM_HALF > 1) ? $clog2(STIM_HALF) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STIM_HALF - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      GATE,
      DONE
   } state_t;

   state_t            state_q;
   logic [GATE_W-1:0] gate_q;
   logic [GATE_W-1:0] gcnt_q;
   logic [DIV_W-1:0]  div_q;
   logic              stim_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  count_q;
   logic              ovf_q;
   logic              s1_q, s2_q, s3_q;
   logic              rise_d;
   logic              last_d;

   always_comb begin
      rise_d = s2_q & ~s3_q;
      last_d = (gcnt_q == (gate_q - GATE_ONE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gate_q  <= '0;
         gcnt_q  <= '0;
         div_q   <= '0;
         stim_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
      end else begin
         s1_q   <= bus.sig_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  gate_q  <= bus.gate_len;
                  busy_q  <= 1'b1;
                  state_q <= ARM;
               end
            end
            ARM: begin
               count_q <= '0;
               ovf_q   <= 1'b0;
               gcnt_q  <= '0;
               div_q   <= '0;
               if (gate_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  // stim rises together with the first GATE cycle
                  stim_q  <= 1'b1;
                  state_q <= GATE;
               end
            end
            GATE: begin
               if (rise_d) begin
                  if (&count_q) ovf_q   <= 1'b1;
                  else          count_q <= count_q + CNT_ONE;
               end
               if (last_d) begin
                  stim_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  gcnt_q <= gcnt_q + GATE_ONE;
                  if (div_q == DIV_LAST) begin
                     div_q  <= '0;
                     stim_q <= ~stim_q;
                  end else begin
                     div_q <= div_q + DIV_ONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.stim_out = stim_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;

endmodule
